// File: rtl/commit_lag_fifo_checker.sv
// Lag-window checker for two lockstep CPU copies: buffers the leader's commit
// observations and compares them, in order, against the follower's commits.
module commit_lag_fifo_checker #(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic                 a_mem_valid,
    input  logic                 a_mem_rdwt,
    input  logic [ADDR_W-1:0]    a_mem_addr,
    input  logic                 a_is_br,
    input  logic                 a_taken,
    input  logic                 b_valid,
    input  logic                 b_mem_valid,
    input  logic                 b_mem_rdwt,
    input  logic [ADDR_W-1:0]    b_mem_addr,
    input  logic                 b_is_br,
    input  logic                 b_taken,
    output logic                 stall_a,
    output logic                 stall_b,
    output logic [1:0]           lead,
    output logic [DEPTH_LOG:0]   count,
    output logic                 commit_deviation,
    output logic                 invalid_program,
    output logic                 overflow_err,
    output logic [DEPTH_LOG:0]   max_lag
);

    typedef struct packed {
        logic              mem_valid;
        logic              mem_rdwt;
        logic [ADDR_W-1:0] mem_addr;
        logic              is_br;
        logic              taken;
    } rec_t;

    typedef enum logic [1:0] {
        LEAD_NONE = 2'b00,
        LEAD_A    = 2'b01,
        LEAD_B    = 2'b10
    } lead_e;

    localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] CNT_ONE  = (DEPTH_LOG+1)'(1);

    function automatic logic mismatch(input rec_t x, input rec_t y);
        return (x.mem_valid & x.mem_rdwt & y.mem_valid & y.mem_rdwt &
                (x.mem_addr != y.mem_addr)) |
               (x.is_br & y.is_br & (x.taken != y.taken));
    endfunction

    lead_e                lead_q, lead_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [DEPTH_LOG:0]   max_q, max_d;
    logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic                 dev_q, dev_d, inv_q, inv_d, ovf_q, ovf_d;
    rec_t                 mem_q [DEPTH];

    rec_t a_rec, b_rec, head, push_rec, cmp_x, cmp_y;
    logic a_acc, b_acc, push, pop, cmp;

    assign a_rec = {a_mem_valid, a_mem_rdwt, a_mem_addr, a_is_br, a_taken};
    assign b_rec = {b_mem_valid, b_mem_rdwt, b_mem_addr, b_is_br, b_taken};
    assign head  = mem_q[rd_ptr_q];

    assign stall_a = (lead_q == LEAD_A) && (count_q == CNT_FULL);
    assign stall_b = (lead_q == LEAD_B) && (count_q == CNT_FULL);
    assign a_acc   = a_valid & ~stall_a;
    assign b_acc   = b_valid & ~stall_b;

    always_comb begin
        lead_d   = lead_q;
        count_d  = count_q;
        push     = 1'b0;
        pop      = 1'b0;
        cmp      = 1'b0;
        push_rec = a_rec;
        cmp_x    = a_rec;
        cmp_y    = b_rec;
        dev_d    = dev_q;
        ovf_d    = ovf_q | (a_valid & stall_a) | (b_valid & stall_b);

        case (lead_q)
            LEAD_NONE: begin
                if (a_acc && b_acc) begin
                    cmp = 1'b1;
                end else if (a_acc || b_acc) begin
                    push     = 1'b1;
                    push_rec = a_acc ? a_rec : b_rec;
                    count_d  = CNT_ONE;
                    lead_d   = a_acc ? LEAD_A : LEAD_B;
                    dev_d    = 1'b1;
                end
            end
            LEAD_A, LEAD_B: begin
                // The leader pushes, the follower pops the oldest record and is compared with it.
                push     = (lead_q == LEAD_A) ? a_acc : b_acc;
                pop      = (lead_q == LEAD_A) ? b_acc : a_acc;
                push_rec = (lead_q == LEAD_A) ? a_rec : b_rec;
                cmp      = pop;
                cmp_x    = head;
                cmp_y    = (lead_q == LEAD_A) ? b_rec : a_rec;
                if (push && !pop) begin
                    count_d = count_q + 1'b1;
                end else if (pop && !push) begin
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_ONE) lead_d = LEAD_NONE;
                end
            end
            default: lead_d = LEAD_NONE;
        endcase

        inv_d = inv_q | (cmp & mismatch(cmp_x, cmp_y));
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lead_q   <= LEAD_NONE;
            count_q  <= '0;
            max_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dev_q    <= 1'b0;
            inv_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            lead_q  <= lead_d;
            count_q <= count_d;
            max_q   <= max_d;
            dev_q   <= dev_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: record storage is not reset; entries are only read after being written behind reset pointers.
    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q] <= push_rec;
    end

    assign lead             = lead_q;
    assign count            = count_q;
    assign commit_deviation = dev_q;
    assign invalid_program  = inv_q;
    assign overflow_err     = ovf_q;
    assign max_lag          = max_q;

endmodule

// File: tb/tb_commit_lag_fifo_checker.sv
// Directed plus randomized bench for commit_lag_fifo_checker against a
// queue-based model that tracks the commit lag as a signed difference.
module tb_commit_lag_fifo_checker;

    localparam int DEPTH     = 4;
    localparam int DEPTH_LOG = 2;
    localparam int ADDR_W    = 4;

    typedef struct packed {
        logic              mv;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              br;
        logic              tk;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              a_valid, a_mem_valid, a_mem_rdwt, a_is_br, a_taken;
    logic [ADDR_W-1:0] a_mem_addr;
    logic              b_valid, b_mem_valid, b_mem_rdwt, b_is_br, b_taken;
    logic [ADDR_W-1:0] b_mem_addr;
    logic              stall_a, stall_b;
    logic [1:0]        lead;
    logic [DEPTH_LOG:0] count;
    logic              commit_deviation, invalid_program, overflow_err;
    logic [DEPTH_LOG:0] max_lag;

    commit_lag_fifo_checker #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_mem_valid(a_mem_valid), .a_mem_rdwt(a_mem_rdwt),
        .a_mem_addr(a_mem_addr), .a_is_br(a_is_br), .a_taken(a_taken),
        .b_valid(b_valid), .b_mem_valid(b_mem_valid), .b_mem_rdwt(b_mem_rdwt),
        .b_mem_addr(b_mem_addr), .b_is_br(b_is_br), .b_taken(b_taken),
        .stall_a(stall_a), .stall_b(stall_b), .lead(lead), .count(count),
        .commit_deviation(commit_deviation), .invalid_program(invalid_program),
        .overflow_err(overflow_err), .max_lag(max_lag)
    );

    int checks = 0;
    int errors = 0;

    // Model state: lag > 0 means A has committed lag more instructions than B.
    rec_t q[$];
    int   lag;
    bit   m_dev, m_inv, m_ovf;
    int   m_max;

    function automatic rec_t ld(input int a);
        rec_t r;
        r = '0;
        r.mv = 1'b1; r.rd = 1'b1; r.addr = ADDR_W'(a);
        return r;
    endfunction

    function automatic rec_t brn(input bit t);
        rec_t r;
        r = '0;
        r.br = 1'b1; r.tk = t;
        return r;
    endfunction

    function automatic bit differs(input rec_t x, input rec_t y);
        bit load_diff, br_diff;
        load_diff = x.mv && x.rd && y.mv && y.rd && (x.addr != y.addr);
        br_diff   = x.br && y.br && (x.tk != y.tk);
        return load_diff || br_diff;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rv, input bit av, input rec_t ar, input bit bv, input rec_t br);
        bit   sa, sb, aa, ba;
        rec_t h;
        if (!rv) begin
            q.delete(); lag = 0; m_dev = 0; m_inv = 0; m_ovf = 0; m_max = 0;
            return;
        end
        sa = (lag == DEPTH);
        sb = (lag == -DEPTH);
        if ((av && sa) || (bv && sb)) m_ovf = 1;
        aa = av && !sa;
        ba = bv && !sb;
        if (aa && ba) begin
            if (lag == 0) m_inv |= differs(ar, br);
            else if (lag > 0) begin h = q.pop_front(); m_inv |= differs(h, br); q.push_back(ar); end
            else begin h = q.pop_front(); m_inv |= differs(h, ar); q.push_back(br); end
        end else if (aa) begin
            if (lag >= 0) begin
                if (lag == 0) m_dev = 1;
                q.push_back(ar);
            end else begin
                h = q.pop_front(); m_inv |= differs(h, ar);
            end
            lag++;
        end else if (ba) begin
            if (lag <= 0) begin
                if (lag == 0) m_dev = 1;
                q.push_back(br);
            end else begin
                h = q.pop_front(); m_inv |= differs(h, br);
            end
            lag--;
        end
        if (q.size() > m_max) m_max = q.size();
    endtask

    task automatic check_all();
        int exp_lead;
        exp_lead = (lag > 0) ? 1 : (lag < 0) ? 2 : 0;
        check("count",            32'(count),            32'(q.size()));
        check("lead",             32'(lead),             32'(exp_lead));
        check("stall_a",          32'(stall_a),          32'(lag == DEPTH));
        check("stall_b",          32'(stall_b),          32'(lag == -DEPTH));
        check("commit_deviation", 32'(commit_deviation), 32'(m_dev));
        check("invalid_program",  32'(invalid_program),  32'(m_inv));
        check("overflow_err",     32'(overflow_err),     32'(m_ovf));
        check("max_lag",          32'(max_lag),          32'(m_max));
    endtask

    task automatic step(input bit rv, input bit av, input rec_t ar, input bit bv, input rec_t br);
        rst = rv;
        a_valid = av; {a_mem_valid, a_mem_rdwt, a_mem_addr, a_is_br, a_taken} = ar;
        b_valid = bv; {b_mem_valid, b_mem_rdwt, b_mem_addr, b_is_br, b_taken} = br;
        model(rv, av, ar, bv, br);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.mv   = 1'($urandom_range(0, 1));
        r.rd   = 1'($urandom_range(0, 1));
        r.addr = ADDR_W'($urandom_range(0, 3));
        r.br   = 1'($urandom_range(0, 1));
        r.tk   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    initial begin
        rec_t nop;
        int   pa, pb;
        nop = '0;
        lag = 0; m_dev = 0; m_inv = 0; m_ovf = 0; m_max = 0;

        step(0, 0, nop, 0, nop);
        step(0, 0, nop, 0, nop);

        for (int i = 0; i < 5; i++) step(1, 1, ld(3), 1, ld(3));

        step(1, 1, ld(5), 0, nop);
        step(1, 1, ld(6), 0, nop);
        step(1, 0, nop, 1, ld(5));
        step(1, 0, nop, 1, ld(6));

        step(1, 1, brn(1), 0, nop);
        step(1, 0, nop, 1, brn(0));
        step(1, 0, nop, 0, nop);
        step(1, 1, ld(2), 1, ld(2));

        step(0, 0, nop, 0, nop);
        for (int i = 0; i < 4; i++) step(1, 1, ld(i), 0, nop);
        step(1, 1, ld(9), 0, nop);
        step(1, 1, ld(9), 0, nop);
        step(1, 0, nop, 1, ld(0));
        for (int i = 1; i < 4; i++) step(1, 0, nop, 1, ld(i));

        step(0, 0, nop, 0, nop);
        for (int i = 0; i < 3; i++) step(1, 0, nop, 1, ld(7));
        for (int i = 0; i < 6; i++) step(1, 1, ld(7), 1, ld(7));

        step(1, 1, ld(1), 1, ld(2));
        step(0, 0, nop, 0, nop);
        for (int i = 0; i < 3; i++) step(1, 1, ld(4), 1, ld(4));

        for (int blk = 0; blk < 8; blk++) begin
            pa = $urandom_range(1, 9);
            pb = $urandom_range(1, 9);
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 49) != 0),
                     ($urandom_range(0, 9) < pa), rand_rec(),
                     ($urandom_range(0, 9) < pb), rand_rec());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
